rs_bank: RTL and testbench

RS_BANK -- requirements
Module: rs_bank

---
 rtl/rs_bank.sv | 192 +++++++++++++++++++
 tb/tb_rs_bank.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_bank.sv
// rs_bank: reservation-station bank. Holds dispatched ALU operations until both
// operands are available (captured from the CDB), then issues the oldest ready
// entry to the functional unit.

`ifndef ROB_TAG_BITS
`define ROB_TAG_BITS 4
`endif

`ifndef ALU_FUNC_BITS
`define ALU_FUNC_BITS 5
`endif

module rs_bank #(
    parameter int unsigned RS_DEPTH = 4,
    parameter int unsigned TAG_W    = `ROB_TAG_BITS,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ALU_W    = `ALU_FUNC_BITS
) (
    input  logic                        clock,
    input  logic                        reset,

    input  logic                        disp_valid,
    input  logic [31:0]                 disp_npc,
    input  logic [31:0]                 disp_inst,
    input  logic [ALU_W-1:0]            disp_alu_func,
    input  logic [TAG_W-1:0]            disp_rob_tag,
    input  logic [XLEN-1:0]             disp_opa,
    input  logic [XLEN-1:0]             disp_opb,
    input  logic                        disp_opa_valid,
    input  logic                        disp_opb_valid,
    output logic                        disp_ready,

    input  logic                        cdb_valid,
    input  logic [TAG_W-1:0]            cdb_tag,
    input  logic [XLEN-1:0]             cdb_value,

    input  logic                        issue_ready,
    output logic                        issue_valid,
    output logic [XLEN-1:0]             issue_opa,
    output logic [XLEN-1:0]             issue_opb,
    output logic [TAG_W-1:0]            issue_tag,
    output logic [ALU_W-1:0]            issue_alu_func,
    output logic [31:0]                 issue_npc,
    output logic [31:0]                 issue_inst,

    input  logic                        flush,
    output logic [$clog2(RS_DEPTH):0]   free_count
);

    localparam int unsigned IDX_W = $clog2(RS_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(RS_DEPTH - 1);

    // Entry storage
    logic [RS_DEPTH-1:0] ent_valid;
    logic [RS_DEPTH-1:0] ent_opa_v;
    logic [RS_DEPTH-1:0] ent_opb_v;
    logic [XLEN-1:0]     ent_opa  [RS_DEPTH];
    logic [XLEN-1:0]     ent_opb  [RS_DEPTH];
    logic [IDX_W-1:0]    ent_age  [RS_DEPTH];
    logic [TAG_W-1:0]    ent_tag  [RS_DEPTH];
    logic [ALU_W-1:0]    ent_func [RS_DEPTH];
    logic [31:0]         ent_npc  [RS_DEPTH];
    logic [31:0]         ent_inst [RS_DEPTH];

    logic                alloc_found;
    logic [IDX_W-1:0]    alloc_idx;
    logic [CNT_W-1:0]    free_cnt;

    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    sel_age;

    logic                disp_fire;
    logic                issue_fire;
    logic                fwd_a;
    logic                fwd_b;

    // Free-entry count and lowest-index free slot from registered valid bits
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        free_cnt    = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (!ent_valid[i]) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!alloc_found) begin
                    alloc_found = 1'b1;
                    alloc_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Oldest ready entry wins; strict '>' keeps ties on the lowest index
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (ent_valid[i] && ent_opa_v[i] && ent_opb_v[i] &&
                (!sel_found || ent_age[i] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = ent_age[i];
            end
        end
    end

    // Issue port driven from registered state only, zeroed when idle
    always_comb begin
        issue_valid    = sel_found;
        issue_opa      = '0;
        issue_opb      = '0;
        issue_tag      = '0;
        issue_alu_func = '0;
        issue_npc      = '0;
        issue_inst     = '0;
        if (sel_found) begin
            issue_opa      = ent_opa[sel_idx];
            issue_opb      = ent_opb[sel_idx];
            issue_tag      = ent_tag[sel_idx];
            issue_alu_func = ent_func[sel_idx];
            issue_npc      = ent_npc[sel_idx];
            issue_inst     = ent_inst[sel_idx];
        end
    end

    // Handshake qualifiers and same-cycle CDB forwarding into dispatch
    always_comb begin
        disp_ready = alloc_found;
        free_count = free_cnt;
        disp_fire  = disp_valid && alloc_found;
        issue_fire = sel_found && issue_ready;
        fwd_a      = !disp_opa_valid && cdb_valid && (disp_opa[TAG_W-1:0] == cdb_tag);
        fwd_b      = !disp_opb_valid && cdb_valid && (disp_opb[TAG_W-1:0] == cdb_tag);
    end

    // Entry state update: reset, flush, wakeup, issue-free, dispatch
    always_ff @(posedge clock) begin
        if (reset) begin
            ent_valid <= '0;
            ent_opa_v <= '0;
            ent_opb_v <= '0;
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                ent_opa[i]  <= '0;
                ent_opb[i]  <= '0;
                ent_age[i]  <= '0;
                ent_tag[i]  <= '0;
                ent_func[i] <= '0;
                ent_npc[i]  <= '0;
                ent_inst[i] <= '0;
            end
        end else if (flush) begin
            ent_valid <= '0;
        end else begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                if (ent_valid[i] && cdb_valid) begin
                    if (!ent_opa_v[i] && ent_opa[i][TAG_W-1:0] == cdb_tag) begin
                        ent_opa[i]   <= cdb_value;
                        ent_opa_v[i] <= 1'b1;
                    end
                    if (!ent_opb_v[i] && ent_opb[i][TAG_W-1:0] == cdb_tag) begin
                        ent_opb[i]   <= cdb_value;
                        ent_opb_v[i] <= 1'b1;
                    end
                end
                if (disp_fire && ent_valid[i] && ent_age[i] != AGE_MAX) begin
                    ent_age[i] <= ent_age[i] + IDX_W'(1);
                end
            end
            if (issue_fire) begin
                ent_valid[sel_idx] <= 1'b0;
            end
            // alloc_idx is always a currently-invalid slot, so it never
            // collides with the entry being freed or woken above
            if (disp_fire) begin
                ent_valid[alloc_idx] <= 1'b1;
                ent_age[alloc_idx]   <= '0;
                ent_tag[alloc_idx]   <= disp_rob_tag;
                ent_func[alloc_idx]  <= disp_alu_func;
                ent_npc[alloc_idx]   <= disp_npc;
                ent_inst[alloc_idx]  <= disp_inst;
                ent_opa[alloc_idx]   <= fwd_a ? cdb_value : disp_opa;
                ent_opa_v[alloc_idx] <= disp_opa_valid || fwd_a;
                ent_opb[alloc_idx]   <= fwd_b ? cdb_value : disp_opb;
                ent_opb_v[alloc_idx] <= disp_opb_valid || fwd_b;
            end
        end
    end

endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: directed scenarios plus randomized traffic for rs_bank, checked
// against a behavioural model of the reservation-station rules.

module tb_rs_bank;

    localparam int unsigned D  = 4;
    localparam int unsigned TW = 4;
    localparam int unsigned XL = 32;
    localparam int unsigned AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          disp_valid = 1'b0;
    logic [31:0]   disp_npc = '0;
    logic [31:0]   disp_inst = '0;
    logic [AW-1:0] disp_alu_func = '0;
    logic [TW-1:0] disp_rob_tag = '0;
    logic [XL-1:0] disp_opa = '0;
    logic [XL-1:0] disp_opb = '0;
    logic          disp_opa_valid = 1'b0;
    logic          disp_opb_valid = 1'b0;
    logic          disp_ready;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [XL-1:0] cdb_value = '0;
    logic          issue_ready = 1'b0;
    logic          issue_valid;
    logic [XL-1:0] issue_opa;
    logic [XL-1:0] issue_opb;
    logic [TW-1:0] issue_tag;
    logic [AW-1:0] issue_alu_func;
    logic [31:0]   issue_npc;
    logic [31:0]   issue_inst;
    logic          flush = 1'b0;
    logic [2:0]    free_count;

    rs_bank #(.RS_DEPTH(D), .TAG_W(TW), .XLEN(XL), .ALU_W(AW)) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_npc(disp_npc), .disp_inst(disp_inst),
        .disp_alu_func(disp_alu_func), .disp_rob_tag(disp_rob_tag),
        .disp_opa(disp_opa), .disp_opb(disp_opb),
        .disp_opa_valid(disp_opa_valid), .disp_opb_valid(disp_opb_valid),
        .disp_ready(disp_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_ready(issue_ready), .issue_valid(issue_valid),
        .issue_opa(issue_opa), .issue_opb(issue_opb), .issue_tag(issue_tag),
        .issue_alu_func(issue_alu_func), .issue_npc(issue_npc), .issue_inst(issue_inst),
        .flush(flush), .free_count(free_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Behavioural model: one record per slot, age counts dispatches seen since entry
    typedef struct {
        bit            v;
        int            age;
        logic [TW-1:0] tag;
        logic [AW-1:0] fn;
        logic [31:0]   npc;
        logic [31:0]   inst;
        logic [XL-1:0] a;
        logic [XL-1:0] b;
        bit            av;
        bit            bv;
    } ent_t;

    ent_t m [D];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int m_sel();
        int best = -1;
        for (int i = 0; i < int'(D); i++)
            if (m[i].v && m[i].av && m[i].bv && (best < 0 || m[i].age > m[best].age))
                best = i;
        return best;
    endfunction

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < int'(D); i++) if (!m[i].v) n++;
        return n;
    endfunction

    task automatic check_outputs();
        int s  = m_sel();
        int fc = m_free();
        check("free_count", 64'(free_count), 64'(fc));
        check("disp_ready", 64'(disp_ready), 64'(fc > 0));
        check("issue_valid", 64'(issue_valid), 64'(s >= 0));
        if (s >= 0) begin
            check("issue_tag",  64'(issue_tag), 64'(m[s].tag));
            check("issue_func", 64'(issue_alu_func), 64'(m[s].fn));
            check("issue_npc",  64'(issue_npc), 64'(m[s].npc));
            check("issue_inst", 64'(issue_inst), 64'(m[s].inst));
            check("issue_opa",  64'(issue_opa), 64'(m[s].a));
            check("issue_opb",  64'(issue_opb), 64'(m[s].b));
        end else begin
            check("issue_a_b_zero", {issue_opa, issue_opb}, 64'd0);
            check("issue_meta_zero", {issue_npc, issue_inst}, 64'd0);
            check("issue_tf_zero", 64'({issue_tag, issue_alu_func}), 64'd0);
        end
    endtask

    task automatic model_update();
        bit pre_v [D];
        int s;
        int f = -1;
        if (reset) begin
            for (int i = 0; i < int'(D); i++) m[i] = '{default: 0};
            return;
        end
        if (flush) begin
            for (int i = 0; i < int'(D); i++) m[i].v = 0;
            return;
        end
        s = m_sel();
        for (int i = 0; i < int'(D); i++) begin
            pre_v[i] = m[i].v;
            if (f < 0 && !m[i].v) f = i;
        end
        for (int i = 0; i < int'(D); i++) begin
            if (pre_v[i] && cdb_valid) begin
                if (!m[i].av && m[i].a[TW-1:0] == cdb_tag) begin m[i].a = cdb_value; m[i].av = 1; end
                if (!m[i].bv && m[i].b[TW-1:0] == cdb_tag) begin m[i].b = cdb_value; m[i].bv = 1; end
            end
        end
        if (s >= 0 && issue_ready) m[s].v = 0;
        if (disp_valid && f >= 0) begin
            for (int i = 0; i < int'(D); i++)
                if (pre_v[i] && m[i].age < int'(D) - 1) m[i].age++;
            m[f].v    = 1;
            m[f].age  = 0;
            m[f].tag  = disp_rob_tag;
            m[f].fn   = disp_alu_func;
            m[f].npc  = disp_npc;
            m[f].inst = disp_inst;
            if (!disp_opa_valid && cdb_valid && disp_opa[TW-1:0] == cdb_tag) begin
                m[f].a = cdb_value; m[f].av = 1;
            end else begin
                m[f].a = disp_opa; m[f].av = disp_opa_valid;
            end
            if (!disp_opb_valid && cdb_valid && disp_opb[TW-1:0] == cdb_tag) begin
                m[f].b = cdb_value; m[f].bv = 1;
            end else begin
                m[f].b = disp_opb; m[f].bv = disp_opb_valid;
            end
        end
    endtask

    task automatic tick();
        check_outputs();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        disp_valid = 0; cdb_valid = 0; issue_ready = 0; flush = 0; reset = 0;
    endtask

    task automatic set_disp(input logic [TW-1:0] tag, input logic [XL-1:0] a, input bit av,
                            input logic [XL-1:0] b, input bit bv);
        disp_valid     = 1;
        disp_rob_tag   = tag;
        disp_alu_func  = AW'(tag + 1);
        disp_npc       = 32'h1000 + 32'(tag) * 4;
        disp_inst      = 32'hC0DE_0000 | 32'(tag);
        disp_opa       = a;
        disp_opa_valid = av;
        disp_opb       = b;
        disp_opb_valid = bv;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
    endtask

    initial begin
        // Power-up: model and DUT leave reset together
        model_update();
        @(posedge clock);
        #1;
        tick();
        idle();
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        check("rst_free_count", 64'(free_count), 64'd4);

        // Operand woken by CDB becomes issuable the next cycle
        set_disp(4'd3, 32'hAAAA_0000, 1, 32'd3, 0);
        tick();
        idle();
        cdb_valid = 1; cdb_tag = 4'd3; cdb_value = 32'h1234_5678;
        tick();
        idle();
        check("wake_issue_valid", 64'(issue_valid), 64'd1);
        check("wake_issue_opb", 64'(issue_opb), 64'h1234_5678);
        check("wake_issue_tag", 64'(issue_tag), 64'd3);
        issue_ready = 1;
        tick();
        idle();
        tick();

        // Full bank ignores dispatch; one issue frees a slot a cycle later
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_disp(TW'(k), 32'd9, 0, 32'h100 + 32'(k), 1);
            tick();
        end
        idle();
        check("full_disp_ready", 64'(disp_ready), 64'd0);
        check("full_free_count", 64'(free_count), 64'd0);
        set_disp(4'd7, 32'h77, 1, 32'h78, 1);
        tick();
        idle();
        check("full_ignore", 64'(free_count), 64'd0);
        cdb_valid = 1; cdb_tag = 4'd9; cdb_value = 32'h99;
        tick();
        idle();
        check("full_oldest_tag", 64'(issue_tag), 64'd0);
        issue_ready = 1;
        tick();
        idle();
        check("after_issue_ready", 64'(disp_ready), 64'd1);
        check("after_issue_free", 64'(free_count), 64'd1);
        check("next_oldest_tag", 64'(issue_tag), 64'd1);

        // Older entry issues first
        do_reset();
        set_disp(4'd1, 32'h11, 1, 32'h12, 1);
        tick();
        set_disp(4'd2, 32'h21, 1, 32'h22, 1);
        tick();
        idle();
        issue_ready = 1;
        check("order_first", 64'(issue_tag), 64'd1);
        tick();
        check("order_second", 64'(issue_tag), 64'd2);
        tick();
        check("order_empty", 64'(issue_valid), 64'd0);
        idle();

        // Same-cycle CDB forwarding into the dispatching entry
        do_reset();
        set_disp(4'd6, 32'h11, 1, 32'd5, 0);
        cdb_valid = 1; cdb_tag = 4'd5; cdb_value = 32'h55;
        tick();
        idle();
        check("fwd_issue_valid", 64'(issue_valid), 64'd1);
        check("fwd_issue_opb", 64'(issue_opb), 64'h55);
        issue_ready = 1;
        tick();
        idle();

        // Stall holds the issue port; flush empties the bank
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_disp(TW'(10 + k), 32'hA0 + 32'(k), 1, 32'hB0 + 32'(k), 1);
            tick();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            check("stall_tag", 64'(issue_tag), 64'd10);
            check("stall_opa", 64'(issue_opa), 64'hA0);
            tick();
        end
        flush = 1;
        tick();
        idle();
        check("flush_free", 64'(free_count), 64'd4);
        check("flush_issue_valid", 64'(issue_valid), 64'd0);

        // Reset mid-operation abandons ready entries
        do_reset();
        set_disp(4'd1, 32'h1, 1, 32'h2, 1);
        tick();
        set_disp(4'd2, 32'h3, 1, 32'h4, 1);
        tick();
        idle();
        reset = 1;
        tick();
        idle();
        check("rst_mid_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_mid_free", 64'(free_count), 64'd4);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            idle();
            if ($urandom_range(0, 9) < 7)
                set_disp(TW'($urandom_range(0, 15)),
                         {$urandom, 4'(0)} | 32'($urandom_range(0, 7)), bit'($urandom_range(0, 2) == 0),
                         {$urandom, 4'(0)} | 32'($urandom_range(0, 7)), bit'($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 1) == 1) begin
                cdb_valid = 1;
                cdb_tag   = TW'($urandom_range(0, 7));
                cdb_value = $urandom;
            end
            issue_ready = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 31) == 0);
            reset       = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
